// File: rtl/screen_writer_pkg.sv
// Shared definitions for the screen writer and the display-side address map.
package screen_writer_pkg;

  // Pixel command modes carried on in_mode.
  typedef enum logic [1:0] {
    MODE_CLEAR  = 2'b00,
    MODE_SET    = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_ATTR   = 2'b11
  } mode_t;

  // Writer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_ATTR = 2'b11
  } state_t;

  // The attribute area (768 bytes) sits directly above the 6144-byte bitmap.
  localparam logic [12:0] ATTR_BASE = 13'h1800;

  // First row number that lies outside the visible bitmap.
  localparam logic [7:0]  ROW_LIMIT = 8'd192;

  // Returns data with only the bit at idx cleared, set or inverted per mode.
  function automatic logic [7:0] apply_pixel(input logic [7:0] data,
                                             input logic [2:0] idx,
                                             input mode_t      mode);
    logic [7:0] mask;
    mask = 8'h01 << idx;
    case (mode)
      MODE_CLEAR:  apply_pixel = data & ~mask;
      MODE_SET:    apply_pixel = data | mask;
      MODE_TOGGLE: apply_pixel = data ^ mask;
      default:     apply_pixel = data;
    endcase
  endfunction

endpackage

// File: rtl/screen_writer_zx_addr_map.sv
// Combinational pixel-to-byte address map for the screen layout.
// Shared with the display fetch logic, so it holds no state.
module zx_addr_map
  import screen_writer_pkg::*;
(
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  output logic [12:0] o_bitmap_addr,
  output logic [12:0] o_attr_addr,
  output logic [2:0]  o_bit_idx
);

  // Bitmap rows are interleaved in thirds of the screen; attributes are per 8x8 cell.
  always_comb begin
    o_bitmap_addr = {i_y[7:6], i_y[2:0], i_y[5:3], i_x[7:3]};
    o_attr_addr   = ATTR_BASE + {3'b000, i_y[7:3], i_x[7:3]};
    // Bit 7 of a byte is the leftmost pixel of its 8-pixel group.
    o_bit_idx     = ~i_x[2:0];
  end

endmodule

// File: rtl/screen_writer.sv
// Pixel command engine: read-modify-write of one bitmap byte, optionally
// followed by an attribute byte write. Off-screen rows are dropped and counted.
//
// Handshake: a command transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE, so a sequence in progress is never interrupted;
// in_valid may be held high and the next command is taken as soon as IDLE returns.
module screen_writer
  import screen_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [1:0]  in_mode,
  input  logic [7:0]  in_attr,
  input  logic        in_attr_we,
  output logic [12:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output state_t      o_dbg_state
);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  mode_t       r_mode;
  logic [7:0]  r_attr;
  logic        r_attr_we;
  logic [7:0]  r_drop_cnt;

  logic        w_accept;
  logic        w_offscreen;
  logic [12:0] w_bitmap_addr;
  logic [12:0] w_attr_addr;
  logic [2:0]  w_bit_idx;

  assign in_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign drop_cnt    = r_drop_cnt;
  assign o_dbg_state = r_state;
  assign w_accept    = in_valid && in_ready;
  assign w_offscreen = (in_y >= ROW_LIMIT);

  zx_addr_map u_addr_map (
    .i_x           (r_x),
    .i_y           (r_y),
    .o_bitmap_addr (w_bitmap_addr),
    .o_attr_addr   (w_attr_addr),
    .o_bit_idx     (w_bit_idx)
  );

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the command on acceptance so inputs may change during the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= 8'd0;
      r_y       <= 8'd0;
      r_mode    <= MODE_CLEAR;
      r_attr    <= 8'd0;
      r_attr_we <= 1'b0;
    end else if (w_accept) begin
      r_x       <= in_x;
      r_y       <= in_y;
      r_mode    <= mode_t'(in_mode);
      r_attr    <= in_attr;
      r_attr_we <= in_attr_we;
    end
  end

  // Saturating count of commands rejected for an off-screen row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_accept && w_offscreen && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_offscreen) begin
          if (in_mode == MODE_ATTR) begin
            w_next = in_attr_we ? ST_ATTR : ST_IDLE;
          end else begin
            w_next = ST_RD;
          end
        end
      end
      ST_RD:   w_next = ST_WR;
      ST_WR:   w_next = r_attr_we ? ST_ATTR : ST_IDLE;
      ST_ATTR: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Memory strobes decoded from the state; everything is quiet in IDLE.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 13'd0;
    mem_wdata = 8'd0;
    case (r_state)
      ST_RD: begin
        mem_re   = 1'b1;
        mem_addr = w_bitmap_addr;
      end
      ST_WR: begin
        // mem_rdata answers the read strobe issued in RD.
        mem_we    = 1'b1;
        mem_addr  = w_bitmap_addr;
        mem_wdata = apply_pixel(mem_rdata, w_bit_idx, r_mode);
      end
      ST_ATTR: begin
        mem_we    = 1'b1;
        mem_addr  = w_attr_addr;
        mem_wdata = r_attr;
      end
      default: begin
        mem_re = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_screen_writer.sv
// Directed bench for screen_writer with a byte-wide screen memory model.
module tb_screen_writer;
  import screen_writer_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [1:0]  in_mode;
  logic [7:0]  in_attr;
  logic        in_attr_we;
  logic [12:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic [7:0]  drop_cnt;
  state_t      dbg_state;

  logic [7:0]  mem [0:8191];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int ov_cnt = 0;

  screen_writer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_mode     (in_mode),
    .in_attr     (in_attr),
    .in_attr_we  (in_attr_we),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .drop_cnt    (drop_cnt),
    .o_dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen memory: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Strobe activity monitor
  always @(negedge clk) begin
    if (mem_re) re_cnt++;
    if (mem_we) we_cnt++;
    if (mem_re && mem_we) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command at a negedge; returns one cycle later with in_valid low.
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] mode,
                       input logic [7:0] attr, input logic attr_we);
    in_x = x; in_y = y; in_mode = mode; in_attr = attr; in_attr_we = attr_we;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Check the memory interface for the current cycle, then advance one cycle.
  task automatic expect_cycle(input string tag, input logic re, input logic we,
                              input logic [12:0] addr, input logic [7:0] wdata,
                              input logic ready);
    check({tag, ".re"},    mem_re,    re);
    check({tag, ".we"},    mem_we,    we);
    check({tag, ".addr"},  mem_addr,  addr);
    check({tag, ".wdata"}, mem_wdata, wdata);
    check({tag, ".ready"}, in_ready,  ready);
    @(negedge clk);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", in_ready, 1);
  endtask

  initial begin
    int re0, we0, ov0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0000] = 8'h00;
    mem[13'h0101] = 8'hFF;
    mem[13'h17FF] = 8'h01;
    mem[13'h0200] = 8'h0F;
    mem_rdata = 8'h00;
    reset = 1'b1; in_valid = 1'b0;
    in_x = 8'd0; in_y = 8'd0; in_mode = 2'b00; in_attr = 8'd0; in_attr_we = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst.ready", in_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.re", mem_re, 0);
    check("rst.we", mem_we, 0);
    check("rst.addr", mem_addr, 0);
    check("rst.wdata", mem_wdata, 0);
    check("rst.drop", drop_cnt, 0);
    check("rst.state", dbg_state, ST_IDLE);
    reset = 1'b0;
    @(negedge clk);

    // Set pixel (0,0): 3-cycle occupancy
    issue(8'd0, 8'd0, 2'b01, 8'h00, 1'b0);
    check("t1.busy", busy, 1);
    expect_cycle("t1.rd", 1, 0, 13'h0000, 8'h00, 0);
    expect_cycle("t1.wr", 0, 1, 13'h0000, 8'h80, 0);
    expect_cycle("t1.idle", 0, 0, 13'h0000, 8'h00, 1);

    // Toggle pixel (9,1) in an all-ones byte
    issue(8'd9, 8'd1, 2'b10, 8'h00, 1'b0);
    expect_cycle("t2.rd", 1, 0, 13'h0101, 8'h00, 0);
    expect_cycle("t2.wr", 0, 1, 13'h0101, 8'hBF, 0);
    expect_cycle("t2.idle", 0, 0, 13'h0000, 8'h00, 1);

    // Clear bottom-right pixel plus attribute: 4-cycle occupancy
    issue(8'd255, 8'd191, 2'b00, 8'h47, 1'b1);
    expect_cycle("t3.rd", 1, 0, 13'h17FF, 8'h00, 0);
    expect_cycle("t3.wr", 0, 1, 13'h17FF, 8'h00, 0);
    expect_cycle("t3.attr", 0, 1, 13'h1AFF, 8'h47, 0);
    expect_cycle("t3.idle", 0, 0, 13'h0000, 8'h00, 1);

    // Attribute-only command goes straight to ATTR
    issue(8'd16, 8'd8, 2'b11, 8'h38, 1'b1);
    expect_cycle("t4.attr", 0, 1, 13'h1822, 8'h38, 0);
    expect_cycle("t4.idle", 0, 0, 13'h0000, 8'h00, 1);

    // Attribute mode without attr_we is a no-op
    issue(8'd16, 8'd8, 2'b11, 8'h38, 1'b0);
    check("t5.busy", busy, 0);
    expect_cycle("t5.idle", 0, 0, 13'h0000, 8'h00, 1);

    // Off-screen row is dropped and counted, saturating at 255
    issue(8'd0, 8'd192, 2'b01, 8'h00, 1'b0);
    check("drop.first", drop_cnt, 1);
    expect_cycle("drop.idle", 0, 0, 13'h0000, 8'h00, 1);
    re0 = re_cnt; we0 = we_cnt;
    in_valid = 1'b1;
    repeat (260) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("drop.sat", drop_cnt, 8'hFF);
    check("drop.no_re", re_cnt - re0, 0);
    check("drop.no_we", we_cnt - we0, 0);

    // Reset in RD aborts the sequence
    issue(8'd8, 8'd0, 2'b01, 8'h00, 1'b0);
    check("rrd.re", mem_re, 1);
    reset = 1'b1;
    #1;
    we0 = we_cnt;
    check("rrd.state", dbg_state, ST_IDLE);
    check("rrd.ready", in_ready, 1);
    check("rrd.busy", busy, 0);
    check("rrd.re0", mem_re, 0);
    check("rrd.addr", mem_addr, 0);
    check("rrd.drop", drop_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rrd.no_we", we_cnt - we0, 0);
    check("rrd.mem_kept", mem[13'h0001], 8'h00);

    // Normal command after the abort: set pixel (3,2) in 0x0F
    issue(8'd3, 8'd2, 2'b01, 8'h00, 1'b0);
    expect_cycle("t6.rd", 1, 0, 13'h0200, 8'h00, 0);
    expect_cycle("t6.wr", 0, 1, 13'h0200, 8'h1F, 0);
    expect_cycle("t6.idle", 0, 0, 13'h0000, 8'h00, 1);

    // Four back-to-back commands with in_valid held high
    re0 = re_cnt; we0 = we_cnt; ov0 = ov_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_x = 8'(k * 8 + 1); in_y = 8'(k + 10); in_mode = 2'b10; in_attr_we = 1'b0;
      wait_ready(10);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_ready(10);
    @(negedge clk);
    check("b2b.re", re_cnt - re0, 4);
    check("b2b.we", we_cnt - we0, 4);
    check("b2b.overlap", ov_cnt - ov0, 0);
    check("all.overlap", ov_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/screen_writer.md
SCREEN_WRITER -- requirements
Module: screen_writer

Interface
REQ-001 Parameters: none; the 6144-byte bitmap, 768-byte attribute area and attribute base 13'h1800 SHALL be fixed constants.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  pixel command present.
REQ-005 in_ready  out  1  command accepted when in_valid && in_ready.
REQ-006 in_x  in  8  pixel column 0..255.
REQ-007 in_y  in  8  pixel row; 0..191 valid.
REQ-008 in_mode  in  2  00 clear, 01 set, 10 toggle, 11 attribute only.
REQ-009 in_attr  in  8  attribute byte: flash, bright, paper[2:0], ink[2:0].
REQ-010 in_attr_we  in  1  also write in_attr to the cell's attribute.
REQ-011 mem_addr  out  13  screen memory byte address.
REQ-012 mem_re  out  1  read strobe; mem_rdata is valid the following cycle.
REQ-013 mem_rdata  in  8  read data.
REQ-014 mem_we  out  1  write strobe.
REQ-015 mem_wdata  out  8  write data.
REQ-016 busy  out  1  high whenever the FSM is not IDLE.
REQ-017 drop_cnt  out  8  saturating count of rejected commands.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR and ATTR.
REQ-019 in_ready SHALL be high only in IDLE.
REQ-020 On acceptance, x, y, mode, attr and attr_we SHALL be registered.
REQ-021 Bitmap address SHALL be {y[7:6], y[2:0], y[5:3], x[7:3]}.
REQ-022 Attribute address SHALL be 13'h1800 + {y[7:3], x[7:3]}, computed in 13 bits.
REQ-023 Bit index SHALL be ~x[2:0], so bit 7 is the leftmost pixel.
REQ-024 IDLE transitions: accept with y>191 SHALL stay in IDLE, increment drop_cnt (saturating at 255) and cause no memory access; accept with mode 11 SHALL go to ATTR if attr_we, else stay in IDLE as a no-op; any other accept SHALL go to RD.
REQ-025 RD SHALL last one cycle, drive mem_addr = bitmap address with mem_re=1, then go to WR.
REQ-026 WR SHALL last one cycle, drive mem_we=1 at the bitmap address, and compute mem_wdata from mem_rdata with only the indexed bit changed: cleared, set or inverted per mode.
REQ-027 After WR the FSM SHALL go to ATTR if attr_we, else to IDLE.
REQ-028 ATTR SHALL last one cycle, drive mem_we=1, mem_addr = attribute address and mem_wdata = attr, then go to IDLE.
REQ-029 mem_re and mem_we SHALL never be high in the same cycle.
REQ-030 mem_re, mem_we, mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-031 Throughput: a pixel-only command SHALL occupy 3 cycles from acceptance to next in_ready; with attribute, 4 cycles.
REQ-032 A read-modify-write SHALL NOT be interrupted; a new command is never accepted mid-sequence.

Reset
REQ-033 While reset is asserted: FSM=IDLE, in_ready=1, busy=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, drop_cnt=0.
REQ-034 Reset asserted in RD, WR or ATTR SHALL abort immediately; the partial write is lost and no further strobe is issued.

Structure
REQ-035 A shared package SHALL hold the mode encoding, the FSM state enum, the ATTR_BASE=13'h1800 constant and the row limit 192.
REQ-036 Address generation (REQ-021, REQ-022) SHALL be one combinational sub-module, zx_addr_map, reusable by the display side.

Verification
REQ-037 x=0, y=0, mode=01, rdata=8'h00 -> RD addr 13'h0000; WR addr 13'h0000, wdata 8'h80; next in_ready after 3 cycles.
REQ-038 x=9, y=1, mode=10, rdata=8'hFF -> addr 13'h0101, wdata 8'hBF.
REQ-039 x=255, y=191, mode=00, attr_we=1, attr=8'h47, rdata=8'h01 -> WR 13'h17FF/8'h00, then ATTR 13'h1AFF/8'h47; 4-cycle occupancy.
REQ-040 y=192 -> no mem strobes, drop_cnt 0->1; 256 such commands -> drop_cnt holds 8'hFF.
REQ-041 Reset pulse during RD -> no mem_we that sequence; outputs at reset values; next command processed normally.
REQ-042 Back-to-back in_valid held high for 4 commands -> exactly 4 RD/WR pairs, mem_re and mem_we never overlapping.
